// File: rtl/dpram_burst_reader_pkg.sv
// Shared widths, stream payload and FSM states for the dual-port RAM burst reader.
package dpram_burst_reader_pkg;

   localparam int unsigned AWIDTH    = 11;
   localparam int unsigned NUM_WORDS = 2048;
   localparam int unsigned DWIDTH    = 64;
   localparam int unsigned LWIDTH    = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic              last;
      logic [DWIDTH-1:0] data;
   } word_t;

endpackage

// File: rtl/dpram_burst_reader_skid_fifo2.sv
// Two-entry skid FIFO; slot0 is always the head, contents hold when idle.
module dpram_burst_reader_skid_fifo2
   import dpram_burst_reader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  word_t      din,
   input  logic       pop,
   output logic [1:0] count,
   output word_t      head
);

   word_t slot0;
   word_t slot1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  slot0 <= din;
                  count <= 2'd1;
               end else if (count == 2'd1) begin
                  slot1 <= din;
                  count <= 2'd2;
               end
            end
            2'b01: begin
               if (count != 2'd0) begin
                  slot0 <= slot1;
                  count <= count - 2'd1;
               end
            end
            2'b11: begin
               // Simultaneous push/pop keeps occupancy; new word lands behind the survivor.
               if (count == 2'd2) begin
                  slot0 <= slot1;
                  slot1 <= din;
               end else begin
                  slot0 <= din;
                  count <= 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = slot0;

endmodule

// File: rtl/dpram_burst_reader.sv
// Burst reader: streams a contiguous, wrapping run of RAM words out through a
// credit-controlled 2-entry skid buffer that absorbs the 1-cycle read latency.
module dpram_burst_reader
   import dpram_burst_reader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [AWIDTH-1:0] base_addr,
   input  logic [LWIDTH-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [AWIDTH-1:0] ram_addr,
   output logic              ram_wren,
   input  logic [DWIDTH-1:0] ram_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_last
);

   state_t            state;
   state_t            state_nxt;
   logic [AWIDTH-1:0] addr;
   logic [LWIDTH-1:0] remaining;
   logic              inflight;
   logic              inflight_last;
   logic [1:0]        count;
   word_t             head;
   word_t             push_word;
   logic              busy_nxt;
   logic              done_nxt;
   logic              pop_c;
   logic              accept_c;
   logic              issue_c;
   logic              drained_c;

   assign pop_c    = m_valid & m_ready;
   // A start coinciding with the done pulse is dropped.
   assign accept_c = (state == IDLE) && start && !done;
   assign issue_c  = (state == READ) && (remaining != '0) &&
                     (({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop_c)));
   // Buffer goes empty at this edge with nothing left in the RAM pipe.
   assign drained_c = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop_c));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept_c) begin
               if (length != '0) begin
                  state_nxt = READ;
                  busy_nxt  = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
               end
            end
         end
         READ: begin
            if (issue_c && (remaining == LWIDTH'(1))) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (done) begin
               state_nxt = IDLE;
            end else if (drained_c) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address/length bookkeeping; AWIDTH-bit increment wraps modulo NUM_WORDS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr          <= '0;
         remaining     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         busy          <= busy_nxt;
         done          <= done_nxt;
         inflight      <= issue_c;
         inflight_last <= issue_c && (remaining == LWIDTH'(1));
         if (accept_c) begin
            addr      <= base_addr;
            remaining <= (length > LWIDTH'(NUM_WORDS)) ? LWIDTH'(NUM_WORDS) : length;
         end else if (issue_c) begin
            addr      <= addr + AWIDTH'(1);
            remaining <= remaining - LWIDTH'(1);
         end
      end
   end

   assign push_word.data = ram_rdata;
   assign push_word.last = inflight_last;

   dpram_burst_reader_skid_fifo2 u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inflight),
      .din   (push_word),
      .pop   (pop_c),
      .count (count),
      .head  (head)
   );

   assign ram_addr = addr;
   assign ram_wren = 1'b0;
   assign m_valid  = (count != 2'd0);
   assign m_data   = head.data;
   assign m_last   = head.last;

endmodule
